// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter for a shared MESI snoop bus. It grants one CPU at a time and
// broadcasts that CPU's message. It then collects acks and shared responses from the
// other CPUs and returns the shared result to the requester with a done pulse.
module snoop_bus_arbiter #(
    parameter int N_CPU   = 4,
    parameter int MSG_W   = 5,
    parameter int SRC_W   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [N_CPU-1:0]       req,
    input  logic [N_CPU*MSG_W-1:0] msg_in,
    input  logic [N_CPU-1:0]       snoop_ack,
    input  logic [N_CPU-1:0]       snoop_shared,
    output logic [N_CPU-1:0]       gnt,
    output logic [N_CPU-1:0]       done,
    output logic                   shared_out,
    output logic                   bus_valid,
    output logic [MSG_W-1:0]       bus_msg,
    output logic [SRC_W-1:0]       bus_src,
    output logic                   timeout_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BCAST = 2'd1;
    localparam logic [1:0] SNOOP = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] winner;
    logic [SRC_W-1:0] cand;
    logic [MSG_W-1:0] msg_arr [N_CPU];
    logic [MSG_W-1:0] win_msg;
    logic             win_noop;
    logic [N_CPU-1:0] src_mask;
    logic [N_CPU-1:0] others;
    logic [N_CPU-1:0] ack_acc;
    logic [N_CPU-1:0] shared_acc;
    logic [N_CPU-1:0] ack_next;
    logic [N_CPU-1:0] shared_next;
    logic [3:0]       count;
    logic             all_acked;
    logic             hit_timeout;

    // Split the flat message bus into per-CPU slices.
    always_comb begin
        for (int i = 0; i < N_CPU; i++) begin
            msg_arr[i] = msg_in[i*MSG_W +: MSG_W];
        end
    end

    // Round-robin pick: the lowest offset from ptr that is requesting wins.
    always_comb begin
        winner = ptr;
        cand   = ptr;
        for (int k = N_CPU - 1; k >= 0; k--) begin
            cand = SRC_W'((int'(ptr) + k) % N_CPU);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    // Decode the winner's message and the source/other-CPU masks for the snoop phase.
    always_comb begin
        win_msg     = msg_arr[winner];
        win_noop    = (win_msg[MSG_W-1 -: 2] == 2'b00);
        src_mask    = N_CPU'(1) << bus_src;
        others      = ~src_mask;
        ack_next    = ack_acc | (snoop_ack & others);
        shared_next = shared_acc | (snoop_shared & others);
        all_acked   = &(ack_next | src_mask);
        // The counter holds the number of SNOOP cycles already elapsed.
        hit_timeout = (count >= 4'(TIMEOUT - 1));
    end

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (|req) state_next = win_noop ? DONE : BCAST;
            BCAST:   state_next = SNOOP;
            SNOOP:   if (all_acked || hit_timeout) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, latched bus message, accumulators, counter and sticky error.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= IDLE;
            ptr         <= '0;
            bus_msg     <= '0;
            bus_src     <= '0;
            ack_acc     <= '0;
            shared_acc  <= '0;
            count       <= '0;
            shared_out  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        bus_msg <= win_msg;
                        bus_src <= winner;
                        if (win_noop) shared_out <= 1'b0;
                    end
                end
                BCAST: begin
                    ack_acc    <= '0;
                    shared_acc <= '0;
                    count      <= '0;
                end
                SNOOP: begin
                    ack_acc    <= ack_next;
                    shared_acc <= shared_next;
                    if (count != 4'hF) count <= count + 4'd1;
                    if (all_acked || hit_timeout) shared_out <= |shared_next;
                    // A full set of acks on the last allowed cycle is not a timeout.
                    if (!all_acked && hit_timeout) timeout_err <= 1'b1;
                end
                DONE: begin
                    ptr <= (bus_src == SRC_W'(N_CPU - 1)) ? '0 : bus_src + SRC_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Grant, done and broadcast strobe decode from the registered state.
    always_comb begin
        gnt       = (state != IDLE) ? src_mask : '0;
        done      = (state == DONE) ? src_mask : '0;
        bus_valid = (state == BCAST);
    end

endmodule
